// File: rtl/timer_pkg.sv
// Shared definitions for the machine-timer bus master and the timer responder it drives.
// Latency: not applicable (types, constants and small helpers only).
// Backpressure: not applicable.
package timer_pkg;

    // Command encodings on req_op.
    typedef enum logic [1:0] {
        OP_RD_MTIME    = 2'd0,
        OP_RD_MTIMECMP = 2'd1,
        OP_WR_MTIMECMP = 2'd2,
        OP_WR_MTIME    = 2'd3
    } op_e;

    // Default responder word addresses (lo/hi pairs).
    localparam logic [31:0] DEF_MTIME_ADDR      = 32'h0020bff8;
    localparam logic [31:0] DEF_MTIME_ADDR_H    = 32'h0020bffc;
    localparam logic [31:0] DEF_MTIMECMP_ADDR   = 32'h00204000;
    localparam logic [31:0] DEF_MTIMECMP_ADDR_H = 32'h00204004;

    // Low-word guard written first when updating mtimecmp: parks the
    // compare value at or above its final target while hi is changed.
    localparam logic [31:0] MTIMECMP_GUARD = 32'hffffffff;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_H1  = 4'd1,
        ST_RD_L   = 4'd2,
        ST_RD_H2  = 4'd3,
        ST_RD_CHK = 4'd4,
        ST_WR_1   = 4'd5,
        ST_WR_2   = 4'd6,
        ST_WR_3   = 4'd7,
        ST_RESP   = 4'd8
    } state_e;

    function automatic logic op_is_write(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_cmp(input op_e op);
        return (op == OP_RD_MTIMECMP) || (op == OP_WR_MTIMECMP);
    endfunction

endpackage

// File: rtl/timer_bus_master.sv
// Turns one 64-bit mtime/mtimecmp command into tear-free 32-bit bus word sequences.
// Latency: accept->resp_valid 5 cycles for reads (+4 per hi retry), 4 cycles for writes.
// Backpressure: req_ready only in IDLE; resp has no backpressure; bus has no wait states.
//
// Ports:
//   clock, reset        synchronous active-high reset
//   req_valid/req_ready command handshake; req_op selects access, req_wdata is the write value
//   resp_valid          one-cycle completion pulse; resp_rdata/resp_err hold until next accept
//   readEnable/writeEnable/writeByteEnable/address/writeData  bus request (Moore, from state)
//   readData            responder data, valid the cycle after readEnable
module timer_bus_master
    import timer_pkg::*;
#(
    parameter int                      DATA_WIDTH      = 32,
    parameter int                      ADDRESS_BITS    = 32,
    parameter logic [ADDRESS_BITS-1:0] MTIME_ADDR      = ADDRESS_BITS'(DEF_MTIME_ADDR),
    parameter logic [ADDRESS_BITS-1:0] MTIME_ADDR_H    = ADDRESS_BITS'(DEF_MTIME_ADDR_H),
    parameter logic [ADDRESS_BITS-1:0] MTIMECMP_ADDR   = ADDRESS_BITS'(DEF_MTIMECMP_ADDR),
    parameter logic [ADDRESS_BITS-1:0] MTIMECMP_ADDR_H = ADDRESS_BITS'(DEF_MTIMECMP_ADDR_H),
    parameter int                      MAX_RETRY       = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [63:0]             req_wdata,
    output logic                    resp_valid,
    output logic [63:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    readEnable,
    output logic                    writeEnable,
    output logic [3:0]              writeByteEnable,
    output logic [ADDRESS_BITS-1:0] address,
    output logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH-1:0]   readData
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_e              state_q;
    state_e              state_d;
    op_e                 op_q;
    logic [63:0]         wdata_q;
    logic [31:0]         hi1_q;
    logic [31:0]         lo_q;
    logic [RETRY_W-1:0]  retry_q;

    logic                    accept;
    logic                    hi_match;
    logic                    retry_left;
    logic [ADDRESS_BITS-1:0] addr_lo;
    logic [ADDRESS_BITS-1:0] addr_hi;
    logic [31:0]             lo_guard;

    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == ST_RESP) && !reset;

    // In RD_CHK the responder is returning the second hi read.
    assign hi_match   = (readData == hi1_q);
    assign retry_left = (retry_q < RETRY_W'(MAX_RETRY));

    assign addr_lo  = op_is_cmp(op_q) ? MTIMECMP_ADDR   : MTIME_ADDR;
    assign addr_hi  = op_is_cmp(op_q) ? MTIMECMP_ADDR_H : MTIME_ADDR_H;
    // mtime gets a zero guard so the low word cannot carry into hi between writes.
    assign lo_guard = (op_q == OP_WR_MTIMECMP) ? MTIMECMP_GUARD : 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_is_write(op_e'(req_op)) ? ST_WR_1 : ST_RD_H1;
                end
            end
            ST_RD_H1:  state_d = ST_RD_L;
            ST_RD_L:   state_d = ST_RD_H2;
            ST_RD_H2:  state_d = ST_RD_CHK;
            ST_RD_CHK: state_d = (hi_match || !retry_left) ? ST_RESP : ST_RD_H1;
            ST_WR_1:   state_d = ST_WR_2;
            ST_WR_2:   state_d = ST_WR_3;
            ST_WR_3:   state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus request decoded from the state register only; reset forces it quiet.
    always_comb begin
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        address     = '0;
        writeData   = '0;
        case (state_q)
            ST_RD_H1, ST_RD_H2: begin
                readEnable = 1'b1;
                address    = addr_hi;
            end
            ST_RD_L: begin
                readEnable = 1'b1;
                address    = addr_lo;
            end
            ST_WR_1: begin
                writeEnable = 1'b1;
                address     = addr_lo;
                writeData   = lo_guard;
            end
            ST_WR_2: begin
                writeEnable = 1'b1;
                address     = addr_hi;
                writeData   = wdata_q[63:32];
            end
            ST_WR_3: begin
                writeEnable = 1'b1;
                address     = addr_lo;
                writeData   = wdata_q[31:0];
            end
            default: ;
        endcase
        if (reset) begin
            readEnable  = 1'b0;
            writeEnable = 1'b0;
            address     = '0;
            writeData   = '0;
        end
    end

    assign writeByteEnable = writeEnable ? 4'hf : 4'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= OP_RD_MTIME;
            wdata_q    <= '0;
            hi1_q      <= '0;
            lo_q       <= '0;
            retry_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= op_e'(req_op);
                        wdata_q    <= req_wdata;
                        retry_q    <= '0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                ST_RD_L:  hi1_q <= readData;
                ST_RD_H2: lo_q  <= readData;
                ST_RD_CHK: begin
                    if (hi_match) begin
                        resp_rdata <= {hi1_q, lo_q};
                    end else if (retry_left) begin
                        retry_q <= retry_q + RETRY_W'(1);
                    end else begin
                        // Out of retries: report the latest hi with the lo read beside it.
                        resp_err   <= 1'b1;
                        resp_rdata <= {readData, lo_q};
                    end
                end
                ST_WR_3:  resp_rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bus_master.sv
module tb_timer_bus_master;
    import timer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        readEnable;
    logic        writeEnable;
    logic [3:0]  writeByteEnable;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    timer_bus_master dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .readEnable      (readEnable),
        .writeEnable     (writeEnable),
        .writeByteEnable (writeByteEnable),
        .address         (address),
        .writeData       (writeData),
        .readData        (readData)
    );

    // Timer responder: single-cycle registered read, word writes, mtime ticks
    // every cycle it is not being written. Stub mode makes mtime-hi reads alternate 0/1.
    logic [63:0] mtime = 64'd0;
    logic [63:0] mtimecmp = '1;
    logic [31:0] rsp_rdata = 32'd0;
    logic        stub_mode = 1'b0;
    logic        stub_hi = 1'b0;
    logic        timer_interrupt;

    assign readData        = rsp_rdata;
    assign timer_interrupt = (mtime >= mtimecmp);

    always @(posedge clock) begin
        if (!stub_mode) stub_hi <= 1'b0;
        if (readEnable) begin
            case (address)
                DEF_MTIME_ADDR:      rsp_rdata <= mtime[31:0];
                DEF_MTIME_ADDR_H: begin
                    if (stub_mode) begin
                        rsp_rdata <= {31'd0, stub_hi};
                        stub_hi   <= ~stub_hi;
                    end else begin
                        rsp_rdata <= mtime[63:32];
                    end
                end
                DEF_MTIMECMP_ADDR:   rsp_rdata <= mtimecmp[31:0];
                DEF_MTIMECMP_ADDR_H: rsp_rdata <= mtimecmp[63:32];
                default:             rsp_rdata <= 32'd0;
            endcase
        end
        if (writeEnable && address == DEF_MTIME_ADDR)        mtime[31:0]  <= writeData;
        else if (writeEnable && address == DEF_MTIME_ADDR_H) mtime[63:32] <= writeData;
        else                                                 mtime        <= mtime + 64'd1;
        if (writeEnable && address == DEF_MTIMECMP_ADDR)   mtimecmp[31:0]  <= writeData;
        if (writeEnable && address == DEF_MTIMECMP_ADDR_H) mtimecmp[63:32] <= writeData;
    end

    // Bus log: every cycle with any non-zero bus output is recorded.
    typedef struct packed {
        logic        re;
        logic        we;
        logic [3:0]  wbe;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    bus_t bus_log[$];
    int   int_cnt = 0;

    always @(posedge clock) begin
        #2;
        if (readEnable || writeEnable || writeByteEnable != 4'h0 || address != 32'h0 || writeData != 32'h0)
            bus_log.push_back({readEnable, writeEnable, writeByteEnable, address, writeData});
        if (timer_interrupt) int_cnt++;
    end

    function automatic bus_t mk(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_t b;
        b.re  = re;
        b.we  = we;
        b.wbe = we ? 4'hf : 4'h0;
        b.a   = a;
        b.d   = d;
        return b;
    endfunction

    // High-level model of the compare register: value last commanded.
    logic [63:0] cmp_model = '1;

    // Issue one request; returns cycles from accept to resp_valid (60 = never seen).
    task automatic send(input logic [1:0] op, input logic [63:0] wd,
                        output int lat, output logic [63:0] rd, output logic er);
        int n;
        req_op = op;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (readEnable !== 1'b0 || writeEnable !== 1'b0 || writeByteEnable !== 4'h0 || address !== 32'h0 || writeData !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: re=%b we=%b wbe=%h a=%h d=%h, want all 0", readEnable, writeEnable, writeByteEnable, address, writeData);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_resp: valid=%b err=%b rdata=%h, want 0/0/0", resp_valid, resp_err, resp_rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_mtimecmp();
        int lat, base, ib;
        logic [63:0] rd;
        logic er;
        bus_t exp_q[3];
        logic bad;
        exp_q[0] = mk(1'b0, 1'b1, 32'h00204000, 32'hffffffff);
        exp_q[1] = mk(1'b0, 1'b1, 32'h00204004, 32'h00000001);
        exp_q[2] = mk(1'b0, 1'b1, 32'h00204000, 32'h00000010);
        base = bus_log.size();
        ib = int_cnt;
        send(OP_WR_MTIMECMP, 64'h00000001_00000010, lat, rd, er);
        cmp_model = 64'h00000001_00000010;
        checks++;
        if (lat != 4) begin errors++; $display("FAIL wcmp_latency: got %0d want 4", lat); end
        checks++;
        if (er !== 1'b0 || rd !== 64'd0) begin errors++; $display("FAIL wcmp_resp: err=%b rdata=%h want 0/0", er, rd); end
        bad = (bus_log.size() - base != 3);
        for (int k = 0; k < 3 && !bad; k++) if (bus_log[base + k] !== exp_q[k]) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL wcmp_bus_seq: %0d entries, first %h, want 3 starting %h", bus_log.size() - base, bus_log[base], exp_q[0]); end
        checks++;
        if (int_cnt != ib) begin errors++; $display("FAIL wcmp_no_irq: interrupt cycles %0d want 0", int_cnt - ib); end
        checks++;
        if (mtimecmp !== cmp_model) begin errors++; $display("FAIL wcmp_value: got %h want %h", mtimecmp, cmp_model); end
    endtask

    task automatic test_read_mtimecmp();
        int lat, base;
        logic [63:0] rd;
        logic er;
        logic bad;
        base = bus_log.size();
        send(OP_RD_MTIMECMP, 64'd0, lat, rd, er);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL rcmp_latency: got %0d want 5", lat); end
        checks++;
        if (rd !== 64'h00000001_00000010 || er !== 1'b0) begin errors++; $display("FAIL rcmp_data: got %h err %b want 0000000100000010 err 0", rd, er); end
        bad = (bus_log.size() - base != 3);
        if (!bad) bad = (bus_log[base] !== mk(1'b1, 1'b0, 32'h00204004, 32'h0)) ||
                        (bus_log[base + 1] !== mk(1'b1, 1'b0, 32'h00204000, 32'h0)) ||
                        (bus_log[base + 2] !== mk(1'b1, 1'b0, 32'h00204004, 32'h0));
        checks++;
        if (bad) begin errors++; $display("FAIL rcmp_bus_seq: %0d entries, want hi/lo/hi reads", bus_log.size() - base); end
    endtask

    task automatic test_carry_retry();
        int lat, base;
        logic [63:0] rd;
        logic er;
        send(OP_WR_MTIME, 64'h00000000_fffffffd, lat, rd, er);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL carry_wr_latency: got %0d want 4", lat); end
        base = bus_log.size();
        send(OP_RD_MTIME, 64'd0, lat, rd, er);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL carry_rd_latency: got %0d want 9", lat); end
        checks++;
        if (rd[63:32] !== 32'd1 || rd[31:0] > 32'd16 || er !== 1'b0) begin errors++; $display("FAIL carry_rd_data: got %h err %b want hi 1, small lo, err 0", rd, er); end
        checks++;
        if (bus_log.size() - base != 6) begin errors++; $display("FAIL carry_rd_reads: got %0d bus cycles want 6", bus_log.size() - base); end
    endtask

    task automatic test_retry_exhaust();
        int lat, base, nhi, nrd;
        logic [63:0] rd;
        logic er;
        stub_mode = 1'b1;
        base = bus_log.size();
        send(OP_RD_MTIME, 64'd0, lat, rd, er);
        stub_mode = 1'b0;
        nhi = 0;
        nrd = 0;
        for (int k = base; k < bus_log.size(); k++) begin
            if (bus_log[k].re) nrd++;
            if (bus_log[k].re && bus_log[k].a == DEF_MTIME_ADDR_H) nhi++;
        end
        checks++;
        if (lat != 17) begin errors++; $display("FAIL exhaust_latency: got %0d want 17", lat); end
        checks++;
        if (er !== 1'b1 || rd[63:32] !== 32'd1) begin errors++; $display("FAIL exhaust_err: err %b hi %h want 1 / 00000001", er, rd[63:32]); end
        checks++;
        if (nrd != 12 || nhi != 8 || bus_log.size() - base != 12) begin errors++; $display("FAIL exhaust_reads: reads %0d hi %0d want 12/8", nrd, nhi); end
    endtask

    task automatic test_reset_mid_write();
        int n;
        logic seen;
        req_op = OP_WR_MTIMECMP;
        req_wdata = 64'h00000002_00000020;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (writeEnable !== 1'b1 || address !== DEF_MTIMECMP_ADDR_H) begin errors++; $display("FAIL rstmid_in_wr2: we=%b a=%h want 1/00204004", writeEnable, address); end
        reset = 1'b1;
        #1;
        checks++;
        if (readEnable !== 1'b0 || writeEnable !== 1'b0 || writeByteEnable !== 4'h0 || address !== 32'h0 || writeData !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_bus_quiet: re=%b we=%b wbe=%h a=%h d=%h want 0", readEnable, writeEnable, writeByteEnable, address, writeData);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_no_resp: resp_valid seen=%b want 0", seen); end
        cmp_model = {cmp_model[63:32], 32'hffffffff};
        checks++;
        if (mtimecmp !== cmp_model) begin errors++; $display("FAIL rstmid_cmp: got %h want %h", mtimecmp, cmp_model); end
    endtask

    task automatic test_back_to_back();
        int n, lat1, lat2;
        logic busy_bad;
        logic [63:0] rd1, rd2, snap;
        req_op = OP_RD_MTIME;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        req_op = OP_RD_MTIMECMP;
        lat1 = 1;
        busy_bad = 1'b0;
        while (resp_valid !== 1'b1 && lat1 < 60) begin
            if (req_ready !== 1'b0) busy_bad = 1'b1;
            @(negedge clock);
            lat1++;
        end
        if (req_ready !== 1'b0) busy_bad = 1'b1;
        rd1 = resp_rdata;
        snap = mtime;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: ready=%b want 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b0;
        lat2 = 1;
        while (resp_valid !== 1'b1 && lat2 < 60) begin
            if (req_ready !== 1'b0) busy_bad = 1'b1;
            @(negedge clock);
            lat2++;
        end
        rd2 = resp_rdata;
        checks++;
        if (lat1 != 5 || lat2 != 5) begin errors++; $display("FAIL b2b_latency: got %0d/%0d want 5/5", lat1, lat2); end
        checks++;
        if (busy_bad) begin errors++; $display("FAIL b2b_ready_low: ready high during sequence, want 0"); end
        checks++;
        if (rd1[63:32] !== snap[63:32] || snap[31:0] - rd1[31:0] < 32'd1 || snap[31:0] - rd1[31:0] > 32'd8) begin
            errors++;
            $display("FAIL b2b_mtime: got %h want a few ticks before %h", rd1, snap);
        end
        checks++;
        if (rd2 !== cmp_model || resp_err !== 1'b0) begin errors++; $display("FAIL b2b_mtimecmp: got %h err %b want %h err 0", rd2, resp_err, cmp_model); end
    endtask

    task automatic test_random();
        int lat, base, exp_lat;
        logic [63:0] rd, wd, mt_ref;
        logic er, bad;
        logic [1:0] op;
        logic [31:0] lo_a, hi_a;
        bus_t exp_q[3];
        mt_ref = 64'd0;
        for (int it = 0; it < 12; it++) begin
            op = (it == 0) ? OP_WR_MTIME : 2'($urandom_range(0, 3));
            wd = {$urandom(), $urandom()};
            if (op == OP_WR_MTIME) wd[31:28] = 4'h0;
            lo_a = (op == OP_RD_MTIMECMP || op == OP_WR_MTIMECMP) ? DEF_MTIMECMP_ADDR : DEF_MTIME_ADDR;
            hi_a = lo_a + 32'd4;
            if (op[1]) begin
                exp_q[0] = mk(1'b0, 1'b1, lo_a, (op == OP_WR_MTIMECMP) ? 32'hffffffff : 32'h0);
                exp_q[1] = mk(1'b0, 1'b1, hi_a, wd[63:32]);
                exp_q[2] = mk(1'b0, 1'b1, lo_a, wd[31:0]);
                exp_lat = 4;
            end else begin
                exp_q[0] = mk(1'b1, 1'b0, hi_a, 32'h0);
                exp_q[1] = mk(1'b1, 1'b0, lo_a, 32'h0);
                exp_q[2] = mk(1'b1, 1'b0, hi_a, 32'h0);
                exp_lat = 5;
            end
            base = bus_log.size();
            send(op, wd, lat, rd, er);
            checks++;
            if (lat != exp_lat || er !== 1'b0) begin errors++; $display("FAIL rnd_latency it%0d op%0d: lat %0d err %b want %0d/0", it, op, lat, er, exp_lat); end
            bad = (bus_log.size() - base != 3);
            for (int k = 0; k < 3 && !bad; k++) if (bus_log[base + k] !== exp_q[k]) bad = 1'b1;
            checks++;
            if (bad) begin errors++; $display("FAIL rnd_bus_seq it%0d op%0d: %0d entries, want 3 starting %h", it, op, bus_log.size() - base, exp_q[0]); end
            checks++;
            case (op)
                OP_WR_MTIMECMP: begin
                    cmp_model = wd;
                    if (rd !== 64'd0) begin errors++; $display("FAIL rnd_wr_rdata it%0d: got %h want 0", it, rd); end
                end
                OP_WR_MTIME: begin
                    mt_ref = wd;
                    if (rd !== 64'd0) begin errors++; $display("FAIL rnd_wr_rdata it%0d: got %h want 0", it, rd); end
                end
                OP_RD_MTIMECMP: begin
                    if (rd !== cmp_model) begin errors++; $display("FAIL rnd_rd_cmp it%0d: got %h want %h", it, rd, cmp_model); end
                end
                default: begin
                    if (rd[63:32] !== mt_ref[63:32] || rd[31:0] < mt_ref[31:0] || rd[31:0] - mt_ref[31:0] > 32'd1000) begin
                        errors++;
                        $display("FAIL rnd_rd_mtime it%0d: got %h want hi %h, lo just above %h", it, rd, mt_ref[63:32], mt_ref[31:0]);
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_write_mtimecmp();
        test_read_mtimecmp();
        test_carry_retry();
        test_retry_exhaust();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
